// File: rtl/gray_wptr_full_if.sv
// Write-side pointer/flag bundle of the async FIFO. The master drives write requests
// and the read-domain Gray pointer. The slave (gray_wptr_full) returns the address, the pointer and the flags.
interface gray_wptr_full_if #(
    parameter int ASIZE = 4
);
    logic             winc;
    logic [ASIZE:0]   rq_gray;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr_gray;
    logic             wfull;
    logic             wovf;
`ifdef WAFULL_EN
    logic             wafull;
`endif

    modport master (
        output winc,
        output rq_gray,
        input  waddr,
        input  wptr_gray,
        input  wfull,
`ifdef WAFULL_EN
        input  wafull,
`endif
        input  wovf
    );

    modport slave (
        input  winc,
        input  rq_gray,
        output waddr,
        output wptr_gray,
        output wfull,
`ifdef WAFULL_EN
        output wafull,
`endif
        output wovf
    );
endinterface

// File: rtl/gray_wptr_full.sv
// Async FIFO write-side pointer block: binary/Gray write pointer, rq_gray synchroniser, full/overflow flags.
// Optional almost-full flag is built when macro WAFULL_EN is defined.
module gray_wptr_full #(
    parameter int ASIZE        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst,
    gray_wptr_full_if.slave bus
);
    if (ASIZE < 2 || SYNC_STAGES < 2 || AFULL_THRESH < 0) begin : g_param_check
        $error("gray_wptr_full: illegal parameter combination");
    end

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ASIZE:0] wbin_r;
    logic [ASIZE:0] wgray_r;
    logic [ASIZE:0] sync_r [SYNC_STAGES];
    logic           wfull_r;
    logic           wovf_r;

    logic           accept_s;
    logic [ASIZE:0] wbin_next_s;
    logic [ASIZE:0] wgray_next_s;
    logic [ASIZE:0] rq_sync_s;
    logic [ASIZE:0] full_cmp_s;

    // Next pointer and the Gray pattern the write pointer has when it is one lap ahead of the read pointer
    always_comb begin
        accept_s     = bus.winc & ~wfull_r;
        wbin_next_s  = wbin_r + {{ASIZE{1'b0}}, accept_s};
        wgray_next_s = bin2gray(wbin_next_s);
        rq_sync_s    = sync_r[SYNC_STAGES-1];
        full_cmp_s   = {~rq_sync_s[ASIZE:ASIZE-1], rq_sync_s[ASIZE-2:0]};
    end

    // Pointer, full flag and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_r  <= {(ASIZE+1){1'b0}};
            wgray_r <= {(ASIZE+1){1'b0}};
            wfull_r <= 1'b0;
            wovf_r  <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wgray_r <= wgray_next_s;
            wfull_r <= (wgray_next_s == full_cmp_s);
            wovf_r  <= wovf_r | (bus.winc & wfull_r);
        end
    end

    // Multi-flop synchroniser for the read-domain Gray pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {(ASIZE+1){1'b0}};
            end
        end else begin
            sync_r[0] <= bus.rq_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign bus.waddr     = wbin_r[ASIZE-1:0];
    assign bus.wptr_gray = wgray_r;
    assign bus.wfull     = wfull_r;
    assign bus.wovf      = wovf_r;

`ifdef WAFULL_EN
    localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'((2 ** ASIZE) - AFULL_THRESH);

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] fill_s;
    logic           wafull_r;

    // Occupancy is computed against the stale synchronised read pointer, so it can only overestimate
    always_comb begin
        rbin_s = gray2bin(rq_sync_s);
        fill_s = wbin_next_s - rbin_s;
    end

    // Registered almost-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wafull_r <= 1'b0;
        end else begin
            wafull_r <= (fill_s >= AFULL_LVL);
        end
    end

    assign bus.wafull = wafull_r;
`endif
endmodule

// File: tb/tb_gray_wptr_full.sv
// Directed testbench for gray_wptr_full (ASIZE=4, SYNC_STAGES=2, AFULL_THRESH=2).
module tb_gray_wptr_full;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gray_wptr_full_if #(.ASIZE(4)) bus ();

    gray_wptr_full #(.ASIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.winc = 1'b0;
        bus.rq_gray = 5'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.winc = 1'b1;
        bus.rq_gray = 5'd0;
        repeat (3) step();
        checks++;
        if (bus.waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", bus.waddr); end
        checks++;
        if (bus.wptr_gray !== 5'd0) begin errors++; $display("FAIL reset_gray got %b exp 00000", bus.wptr_gray); end
        checks++;
        if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", bus.wfull); end
        checks++;
        if (bus.wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf got %b exp 0", bus.wovf); end
        bus.winc = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [4:0] cnt;
        bus.winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            cnt = 5'(i);
            checks++;
            if (bus.wptr_gray !== gray5(cnt)) begin
                errors++; $display("FAIL fill_gray[%0d] got %b exp %b", i, bus.wptr_gray, gray5(cnt));
            end
            checks++;
            if (bus.wfull !== (i == 16)) begin
                errors++; $display("FAIL fill_wfull[%0d] got %b exp %b", i, bus.wfull, (i == 16));
            end
        end
        checks++;
        if (bus.waddr !== 4'd0) begin errors++; $display("FAIL fill_waddr got %0d exp 0", bus.waddr); end
        checks++;
        if (bus.wptr_gray !== 5'b11000) begin errors++; $display("FAIL fill_final_gray got %b exp 11000", bus.wptr_gray); end
    endtask

    task automatic test_overflow();
        bus.winc = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.waddr !== 4'd0 || bus.wptr_gray !== 5'b11000) begin
            errors++; $display("FAIL ovf_hold got waddr=%0d gray=%b exp 0/11000", bus.waddr, bus.wptr_gray);
        end
        checks++;
        if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.wovf); end
        bus.winc = 1'b0;
        repeat (2) step();
        checks++;
        if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.wovf); end
    endtask

    task automatic test_release();
        logic exp_full;
        bus.rq_gray = 5'b00001;
        bus.winc = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            exp_full = (e < 3);
            checks++;
            if (bus.wfull !== exp_full) begin
                errors++; $display("FAIL release_wfull[edge %0d] got %b exp %b", e, bus.wfull, exp_full);
            end
            checks++;
            if (bus.wptr_gray !== 5'b11000) begin
                errors++; $display("FAIL release_hold[edge %0d] got %b exp 11000", e, bus.wptr_gray);
            end
        end
        step();
        checks++;
        if (bus.wptr_gray !== 5'b11001) begin errors++; $display("FAIL release_gray got %b exp 11001", bus.wptr_gray); end
        checks++;
        if (bus.waddr !== 4'd1) begin errors++; $display("FAIL release_waddr got %0d exp 1", bus.waddr); end
        checks++;
        if (bus.wfull !== 1'b1) begin errors++; $display("FAIL refull got %b exp 1", bus.wfull); end
        bus.winc = 1'b0;
        step();
        checks++;
        if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_before_rst got %b exp 1", bus.wovf); end
        do_reset();
        checks++;
        if (bus.wovf !== 1'b0 || bus.wptr_gray !== 5'd0) begin
            errors++; $display("FAIL ovf_cleared got wovf=%b gray=%b exp 0/00000", bus.wovf, bus.wptr_gray);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] wcnt;
        logic [4:0] rbin;
        logic [4:0] prev;
        logic       wrapped;
        do_reset();
        wcnt = 5'd0;
        rbin = 5'd0;
        prev = 5'd0;
        wrapped = 1'b0;
        bus.winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            wcnt = wcnt + 5'd1;
            if (wcnt == 5'd0) wrapped = 1'b1;
            if (5'(wcnt - rbin) > 5'd3) rbin = rbin + 5'd1;
            bus.rq_gray = gray5(rbin);
            checks++;
            if (bus.wptr_gray !== gray5(wcnt) || bus.waddr !== wcnt[3:0]) begin
                errors++; $display("FAIL wrap_ptr[%0d] got gray=%b waddr=%0d exp %b/%0d", i, bus.wptr_gray, bus.waddr, gray5(wcnt), wcnt[3:0]);
            end
            checks++;
            if ($countones(bus.wptr_gray ^ prev) != 1) begin
                errors++; $display("FAIL wrap_hamming[%0d] got %b -> %b exp one-bit step", i, prev, bus.wptr_gray);
            end
            checks++;
            if (bus.wfull !== 1'b0) begin errors++; $display("FAIL wrap_false_full[%0d] got %b exp 0", i, bus.wfull); end
            prev = bus.wptr_gray;
        end
        bus.winc = 1'b0;
        checks++;
        if (wrapped !== 1'b1 || bus.wptr_gray !== gray5(5'd8)) begin
            errors++; $display("FAIL wrap_end got gray=%b exp %b", bus.wptr_gray, gray5(5'd8));
        end
    endtask

`ifdef WAFULL_EN
    task automatic test_afull();
        do_reset();
        bus.winc = 1'b1;
        repeat (13) step();
        bus.winc = 1'b0;
        checks++;
        if (bus.wafull !== 1'b0) begin errors++; $display("FAIL afull_13 got %b exp 0", bus.wafull); end
        bus.winc = 1'b1;
        step();
        bus.winc = 1'b0;
        checks++;
        if (bus.wafull !== 1'b1) begin errors++; $display("FAIL afull_14 got %b exp 1", bus.wafull); end
        checks++;
        if (bus.wfull !== 1'b0) begin errors++; $display("FAIL afull_wfull got %b exp 0", bus.wfull); end
    endtask
`endif

    initial begin
        bus.winc = 1'b0;
        bus.rq_gray = 5'd0;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
`ifdef WAFULL_EN
        test_afull();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
